// File: rtl/dsp_seq_pkg.sv
// rtl/dsp_seq_pkg.sv - shared types, widths and OPMODE encodings for the MAC sequencer
package dsp_seq_pkg;

    localparam int P_W = 48;
    localparam int M_W = 36;
    localparam int D_W = 18;

    // X mux in bits [1:0], Z mux in bits [3:2]; pre-adder, add/sub and carry bits stay 0
    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;
    localparam logic [7:0] OPM_HOLD  = 8'h08;
    localparam logic [7:0] OPM_IDLE  = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_FIRST = 2'd1,
        TAG_ACC   = 2'd2,
        TAG_HOLD  = 2'd3
    } tag_e;

    function automatic logic [7:0] tag_to_opmode(input tag_e tag);
        logic [7:0] opm;
        case (tag)
            TAG_FIRST: opm = OPM_FIRST;
            TAG_ACC:   opm = OPM_ACC;
            TAG_HOLD:  opm = OPM_HOLD;
            default:   opm = OPM_IDLE;
        endcase
        return opm;
    endfunction

endpackage

// File: rtl/dsp_seq_tag_pipe.sv
// rtl/dsp_seq_tag_pipe.sv - delay line aligning accumulate tags with the slice M register
module dsp_seq_tag_pipe
    import dsp_seq_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  tag_e       tag_i,
    output logic [7:0] opmode_o
);

    tag_e pipe_q [DEPTH];

    // Shift tags one stage per cycle; reset empties the pipe so OPMODE idles
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= TAG_NONE;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign opmode_o = tag_to_opmode(pipe_q[DEPTH-1]);

endmodule

// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - length-N MAC controller for one DSP slice; DSP_SEQ_STALL_CNT_EN adds stall_cnt
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int LEN_W     = 16,
    parameter int OP_DELAY  = 1,
    parameter int RES_DELAY = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [D_W-1:0]   s_a,
    input  logic [D_W-1:0]   s_b,
    output logic [D_W-1:0]   dsp_a,
    output logic [D_W-1:0]   dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_ce,
    output logic             dsp_rst,
    input  logic [P_W-1:0]   dsp_p,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [P_W-1:0]   res_data
`ifdef DSP_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    localparam int DRAIN_W = (RES_DELAY < 1) ? 1 : $clog2(RES_DELAY + 1);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [P_W-1:0]     res_data_q, res_data_d;
    logic [D_W-1:0]     a_q, a_d;
    logic [D_W-1:0]     b_q, b_d;
    tag_e               tag_q, tag_d;
    logic               rst_q;

    // Next-state, operand capture and tag selection; outputs decode from the current state
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        res_data_d = res_data_q;
        a_d        = a_q;
        b_d        = b_q;
        tag_d      = TAG_NONE;
        s_ready    = 1'b0;
        res_valid  = 1'b0;
        busy       = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_len != '0) begin
                        len_d   = cfg_len;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        res_data_d = '0;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                s_ready = 1'b1;
                tag_d   = TAG_HOLD;
                if (s_valid) begin
                    a_d   = s_a;
                    b_d   = s_b;
                    tag_d = (cnt_q == '0) ? TAG_FIRST : TAG_ACC;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        drain_d = DRAIN_W'(RES_DELAY);
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                tag_d = TAG_HOLD;
                if (drain_q == '0) begin
                    res_data_d = dsp_p;
                    state_d    = ST_DONE;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            drain_q    <= '0;
            res_data_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            tag_q      <= TAG_NONE;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            res_data_q <= res_data_d;
            a_q        <= a_d;
            b_q        <= b_d;
            tag_q      <= tag_d;
        end
    end

    // Slice reset follows our reset, delayed one edge so the slice sees a clean pulse
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rst_q <= 1'b1;
        end else begin
            rst_q <= 1'b0;
        end
    end

    // The tag registered with the operands still needs OP_DELAY more stages to meet M
    dsp_seq_tag_pipe #(
        .DEPTH (OP_DELAY)
    ) u_tag_pipe (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .tag_i    (tag_q),
        .opmode_o (dsp_opmode)
    );

    assign dsp_a    = a_q;
    assign dsp_b    = b_q;
    assign dsp_ce   = 1'b1;
    assign dsp_rst  = rst_q;
    assign res_data = res_data_q;

`ifdef DSP_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Count RUN cycles starved of operands, saturating; cleared when a start is accepted
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == ST_IDLE && start) begin
            stall_cnt_d = '0;
        end else if (state_q == ST_RUN && !s_valid && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb/tb_dsp_mac_sequencer.sv - scoreboard bench for dsp_mac_sequencer with a behavioural DSP slice
module tb_dsp_mac_sequencer;
    import dsp_seq_pkg::*;

    logic              CLK;
    logic              RST_N;
    logic              start;
    logic [15:0]       cfg_len;
    logic              busy;
    logic              s_valid;
    logic              s_ready;
    logic [D_W-1:0]    s_a;
    logic [D_W-1:0]    s_b;
    logic [D_W-1:0]    dsp_a;
    logic [D_W-1:0]    dsp_b;
    logic [7:0]        dsp_opmode;
    logic              dsp_ce;
    logic              dsp_rst;
    logic [P_W-1:0]    dsp_p;
    logic              res_valid;
    logic              res_ready;
    logic [P_W-1:0]    res_data;
`ifdef DSP_SEQ_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [D_W-1:0] pa[$];
    logic [D_W-1:0] pb[$];
    logic [P_W-1:0] exp_q[$];
    logic [7:0]     opm_log[$];
    int             txn_lat;
    logic [P_W-1:0] txn_got;
    bit             txn_to;
    logic [D_W-1:0] last_a;

    dsp_mac_sequencer dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start),
        .cfg_len    (cfg_len),
        .busy       (busy),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_a        (s_a),
        .s_b        (s_b),
        .dsp_a      (dsp_a),
        .dsp_b      (dsp_b),
        .dsp_opmode (dsp_opmode),
        .dsp_ce     (dsp_ce),
        .dsp_rst    (dsp_rst),
        .dsp_p      (dsp_p),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data)
`ifdef DSP_SEQ_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural slice: A1/B1, M, OPMODE and P registers, unsigned
    logic [D_W-1:0] sl_a1, sl_b1;
    logic [M_W-1:0] sl_m;
    logic [7:0]     sl_opm;
    always @(posedge CLK) begin
        if (dsp_rst) begin
            sl_a1  <= '0;
            sl_b1  <= '0;
            sl_m   <= '0;
            sl_opm <= '0;
            dsp_p  <= '0;
        end else if (dsp_ce) begin
            sl_a1  <= dsp_a;
            sl_b1  <= dsp_b;
            sl_m   <= sl_a1 * sl_b1;
            sl_opm <= dsp_opmode;
            dsp_p  <= ((sl_opm[1:0] == 2'b01) ? {{(P_W-M_W){1'b0}}, sl_m} : '0)
                    + ((sl_opm[3:2] == 2'b10) ? dsp_p : '0);
        end
    end

    function automatic logic [P_W-1:0] model_sum();
        logic [P_W-1:0] acc = '0;
        for (int i = 0; i < pa.size(); i++) begin
            acc += P_W'(pa[i]) * P_W'(pb[i]);
        end
        return acc;
    endfunction

    // Drives start then the pairs in pa/pb with `gap` idle cycles between them, while
    // counting cycles from start until res_valid; called at a negedge
    task automatic run_txn(input int gap);
        int n = pa.size();
        opm_log.delete();
        fork
            begin
                start   = 1'b1;
                cfg_len = 16'(n);
                @(negedge CLK);
                start = 1'b0;
                for (int i = 0; i < n; i++) begin
                    int g = 0;
                    s_valid = 1'b1;
                    s_a     = pa[i];
                    s_b     = pb[i];
                    while (!s_ready && g < 100) begin
                        @(negedge CLK);
                        g++;
                    end
                    @(negedge CLK);
                    s_valid = 1'b0;
                    last_a  = pa[i];
                    if (i != n - 1) repeat (gap) @(negedge CLK);
                end
            end
            begin
                txn_lat = 0;
                do begin
                    @(negedge CLK);
                    txn_lat++;
                    opm_log.push_back(dsp_opmode);
                end while (!res_valid && txn_lat < 300);
                txn_to  = !res_valid;
                txn_got = res_data;
            end
        join
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b want=0", busy); end
        tests_run++; if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_s_ready got=%b want=0", s_ready); end
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
        tests_run++; if (res_data !== '0) begin tests_failed++; $display("FAIL reset_res_data got=%h want=0", res_data); end
        tests_run++; if ({dsp_a, dsp_b} !== '0) begin tests_failed++; $display("FAIL reset_dsp_ab got=%h/%h want=0/0", dsp_a, dsp_b); end
        tests_run++; if (dsp_opmode !== 8'h00) begin tests_failed++; $display("FAIL reset_opmode got=%h want=00", dsp_opmode); end
        tests_run++; if (dsp_ce !== 1'b1) begin tests_failed++; $display("FAIL reset_ce got=%b want=1", dsp_ce); end
        tests_run++; if (dsp_rst !== 1'b1) begin tests_failed++; $display("FAIL reset_dsp_rst got=%b want=1", dsp_rst); end
`ifdef DSP_SEQ_STALL_CNT_EN
        tests_run++; if (stall_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
`endif
        RST_N = 1'b1;
        @(negedge CLK);
        tests_run++; if (dsp_rst !== 1'b0) begin tests_failed++; $display("FAIL release_dsp_rst got=%b want=0", dsp_rst); end
        last_a = '0;
    endtask

    task automatic test_basic();
        logic [7:0] exp_opm [8] = '{8'h00, 8'h00, 8'h01, 8'h09, 8'h09, 8'h08, 8'h08, 8'h08};
        logic [P_W-1:0] exp;
        pa = '{18'd2, 18'd4, 18'd10};
        pb = '{18'd3, 18'd5, 18'd7};
        exp_q.push_back(model_sum());
        run_txn(0);
        exp = exp_q.pop_front();
        tests_run++; if (txn_to) begin tests_failed++; $display("FAIL basic_timeout res_valid never rose"); end
        tests_run++; if (txn_got !== exp) begin tests_failed++; $display("FAIL basic_result got=%0d want=%0d", txn_got, exp); end
        tests_run++; if (txn_lat != 8) begin tests_failed++; $display("FAIL basic_latency got=%0d want=8", txn_lat); end
        for (int i = 0; i < 8 && i < opm_log.size(); i++) begin
            tests_run++;
            if (opm_log[i] !== exp_opm[i]) begin
                tests_failed++; $display("FAIL basic_opmode[%0d] got=%h want=%h", i + 1, opm_log[i], exp_opm[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp_opm [8] = '{8'h01, 8'h08, 8'h08, 8'h09, 8'h08, 8'h08, 8'h09, 8'h08};
        logic [P_W-1:0] exp;
        pa = '{18'd2, 18'd4, 18'd10};
        pb = '{18'd3, 18'd5, 18'd7};
        exp_q.push_back(model_sum());
        run_txn(2);
        exp = exp_q.pop_front();
        tests_run++; if (txn_to) begin tests_failed++; $display("FAIL stall_timeout res_valid never rose"); end
        tests_run++; if (txn_got !== exp) begin tests_failed++; $display("FAIL stall_result got=%0d want=%0d", txn_got, exp); end
        tests_run++; if (txn_lat != 12) begin tests_failed++; $display("FAIL stall_latency got=%0d want=12", txn_lat); end
        for (int i = 0; i < 8 && i + 2 < opm_log.size(); i++) begin
            tests_run++;
            if (opm_log[i+2] !== exp_opm[i]) begin
                tests_failed++; $display("FAIL stall_opmode[%0d] got=%h want=%h", i + 3, opm_log[i+2], exp_opm[i]);
            end
        end
`ifdef DSP_SEQ_STALL_CNT_EN
        tests_run++; if (stall_cnt !== 16'd4) begin tests_failed++; $display("FAIL stall_cnt got=%0d want=4", stall_cnt); end
`endif
    endtask

    task automatic test_len_zero();
        logic [D_W-1:0] a_before = last_a;
        pa.delete();
        pb.delete();
        exp_q.push_back(model_sum());
        run_txn(0);
        tests_run++; if (txn_lat != 1) begin tests_failed++; $display("FAIL len0_latency got=%0d want=1", txn_lat); end
        tests_run++; if (txn_got !== exp_q.pop_front()) begin tests_failed++; $display("FAIL len0_result got=%h want=0", txn_got); end
        tests_run++; if (dsp_a !== a_before) begin tests_failed++; $display("FAIL len0_dsp_a got=%h want=%h", dsp_a, a_before); end
        @(negedge CLK);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL len0_back_to_idle busy=%b want=0", busy); end
    endtask

    task automatic test_max_operands();
        logic [P_W-1:0] exp;
        pa = '{18'h3FFFF, 18'h3FFFF};
        pb = '{18'h3FFFF, 18'h3FFFF};
        exp_q.push_back(model_sum());
        run_txn(0);
        exp = exp_q.pop_front();
        tests_run++; if (txn_got !== exp) begin tests_failed++; $display("FAIL max_result got=%h want=%h", txn_got, exp); end
        tests_run++; if (txn_lat != 7) begin tests_failed++; $display("FAIL max_latency got=%0d want=7", txn_lat); end
    endtask

    task automatic test_reset_mid_run();
        logic [P_W-1:0] exp;
        @(negedge CLK);
        start = 1'b1; cfg_len = 16'd3;
        @(negedge CLK);
        start = 1'b0; s_valid = 1'b1; s_a = 18'd9; s_b = 18'd9;
        @(negedge CLK);
        s_valid = 1'b0;
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy got=%b want=0", busy); end
        tests_run++; if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL midrst_s_ready got=%b want=0", s_ready); end
        tests_run++; if (dsp_rst !== 1'b1) begin tests_failed++; $display("FAIL midrst_dsp_rst got=%b want=1", dsp_rst); end
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_res_valid got=%b want=0", res_valid); end
        tests_run++; if (dsp_a !== '0) begin tests_failed++; $display("FAIL midrst_dsp_a got=%h want=0", dsp_a); end
        RST_N = 1'b1;
        last_a = '0;
        @(negedge CLK);
        pa = '{18'd5};
        pb = '{18'd5};
        exp_q.push_back(model_sum());
        run_txn(0);
        exp = exp_q.pop_front();
        tests_run++; if (txn_got !== exp) begin tests_failed++; $display("FAIL midrst_after_result got=%0d want=%0d", txn_got, exp); end
    endtask

    task automatic test_backpressure();
        logic [P_W-1:0] exp;
        @(negedge CLK);
        res_ready = 1'b0;
        pa = '{18'd6};
        pb = '{18'd7};
        exp_q.push_back(model_sum());
        run_txn(0);
        exp = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            tests_run++; if (res_valid !== 1'b1) begin tests_failed++; $display("FAIL hold_valid[%0d] got=%b want=1", i, res_valid); end
            tests_run++; if (res_data !== exp) begin tests_failed++; $display("FAIL hold_data[%0d] got=%0d want=%0d", i, res_data, exp); end
            start   = (i == 2);
            cfg_len = 16'd1;
            @(negedge CLK);
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(negedge CLK);
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL release_valid got=%b want=0", res_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL release_busy got=%b want=0", busy); end
        @(negedge CLK);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ignored_start busy=%b want=0", busy); end
    endtask

    initial begin
        RST_N = 1'b0; start = 1'b0; cfg_len = '0; s_valid = 1'b0;
        s_a = '0; s_b = '0; res_ready = 1'b1; last_a = '0;
        test_reset();
        test_basic();
        @(negedge CLK);
        test_stall();
        @(negedge CLK);
        test_len_zero();
        test_max_operands();
        test_reset_mid_run();
        test_backpressure();
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
Controller that runs the DSP48A1-style slice (pre-adder/multiplier/post-adder) as a length-N multiply-accumulate engine: P = sum of a[i]*b[i] for i = 0..N-1.
- Accepts operand pairs over a valid/ready stream.
- Drives the slice's A/B/OPMODE/CE/RST ports with correct pipeline alignment.
- Captures the 48-bit P after pipeline drain and returns it over a valid/ready result port.
- Sits between a host/stream source and one slice instance configured A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT".

Parameters:
LEN_W, 16, width of the transaction length field.
OP_DELAY, 1, cycles from operand appearing on dsp_a/dsp_b to the cycle its OPMODE must be driven.
RES_DELAY, 3, cycles from the last operand appearing on dsp_a/dsp_b to dsp_p holding the final sum.

Ports:
CLK  in  1  single clock; all logic on its rising edge.
RST_N  in  1  synchronous active-low reset.
start  in  1  begin a transaction; sampled only in IDLE.
cfg_len  in  LEN_W  number of operand pairs; latched when start is accepted.
busy  out  1  high in any state other than IDLE.
s_valid  in  1  operand pair valid.
s_ready  out  1  sequencer accepts a pair.
s_a  in  18  unsigned multiplicand.
s_b  in  18  unsigned multiplier.
dsp_a  out  18  to slice A.
dsp_b  out  18  to slice B.
dsp_opmode  out  8  to slice OPMODE.
dsp_ce  out  1  drives every CE of the slice.
dsp_rst  out  1  drives every RST of the slice.
dsp_p  in  48  from slice P.
res_valid  out  1  result available.
res_ready  in  1  result consumer ready.
res_data  out  48  accumulated result.

Behaviour:
- Clocking and reset: one clock (CLK). Reset is synchronous and active-low (RST_N). While RST_N=0 at a clock edge:
  - State goes to IDLE.
  - s_ready, res_valid and busy go to 0.
  - res_data, dsp_a and dsp_b go to 0.
  - dsp_opmode goes to 8'h00.
  - dsp_ce goes to 1.
  - dsp_rst goes to 1. It is registered and falls on the first edge with RST_N=1.
- Reset mid-transaction aborts immediately. No result is produced. All tag and delay state is cleared.
- OPMODE encodings:
  - OPM_FIRST = 8'h01 (X=M, Z=0).
  - OPM_ACC = 8'h09 (X=M, Z=P).
  - OPM_HOLD = 8'h08 (X=0, Z=P).
  - OPM_IDLE = 8'h00.
  - Bits 4–7 are always 0: pre-adder bypassed, add, carry-in 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - s_ready=0.
  - On start=1 with cfg_len != 0: latch the length, clear the pair count, go to RUN.
  - On start=1 with cfg_len == 0: go to DONE with res_data=0.
- RUN:
  - s_ready=1.
  - Each handshake (s_valid & s_ready) at cycle k registers s_a/s_b onto dsp_a/dsp_b (visible at k+1) and pushes a tag into the tag pipe. The tag is FIRST for the first pair, otherwise ACC.
  - A cycle with no handshake pushes a HOLD tag.
  - The tag pipe delays tags by OP_DELAY cycles and drives dsp_opmode. Stalls therefore never corrupt P.
  - The handshake of pair number len goes to DRAIN, drain counter = RES_DELAY.
- DRAIN:
  - s_ready=0. HOLD tags are pushed.
  - The counter decrements each cycle.
  - When the counter reaches 0, capture dsp_p into res_data and go to DONE.
- DONE:
  - res_valid=1 and res_data is stable.
  - On res_ready=1, go to IDLE; res_valid falls on the next edge.
- start is ignored outside IDLE.
- After DRAIN completes, dsp_opmode returns to OPM_IDLE.
- Arithmetic is unsigned, 36-bit product into a 48-bit accumulator. Wrap-around is modulo 2^48 and no flag is raised.
- Latency:
  - Last-pair handshake to res_valid = 1 + RES_DELAY + 1 cycles.
  - N pairs with no stalls take N + RES_DELAY + 2 cycles from start to res_valid.

Optional Feature:
DSP_SEQ_STALL_CNT_EN
- Defined: adds output stall_cnt[15:0], cleared on start accept.
  - Increments each RUN cycle with s_valid=0.
  - Saturates at 16'hFFFF.
  - Frozen outside RUN.
  - Reset value 0.
- Undefined: no port and no counter logic. Function is otherwise identical.

Decomposition:
- Package dsp_seq_pkg: state enum (IDLE/RUN/DRAIN/DONE), tag enum (FIRST/ACC/HOLD/NONE), OPM_* constants, 48/36/18 width constants.
- Sub-module dsp_seq_tag_pipe: OP_DELAY-deep shift register of tags with synchronous active-low reset to NONE. It outputs the mapped dsp_opmode.

Test Plan:
- Len=3; pairs (2,3),(4,5),(10,7), no stalls -> res_data=96, res_valid exactly 3+3+2 cycles after start; dsp_opmode sequence 01,09,09,08…
- Same pairs with s_valid low for 2 cycles between pairs -> res_data=96; HOLD (08) appears during gaps; with DSP_SEQ_STALL_CNT_EN, stall_cnt=4.
- Len=0 start -> DONE next cycle, res_data=0, no dsp_a change.
- Len=2; (3FFFF,3FFFF) twice -> res_data=2*(2^18-1)^2 = 0x1_FFFF0_0002 (mod 2^48).
- Reset asserted during RUN after 1 pair -> next edge: IDLE, busy=0, s_ready=0, dsp_rst=1; a subsequent len=1 (5,5) transaction gives 25.
- res_ready held low 5 cycles in DONE -> res_valid and res_data held stable; start pulses ignored; after res_ready, IDLE.
